imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered immediate-decode stage for the ID pipeline. Accepts one fetched instruction per cycle over a valid/ready handshake, extracts and sign-extends the immediate for every RV32I/RV64I format (including B-type and shift-amount forms), and computes the PC-relative target. Output is buffered by a two-entry skid so `in_ready` never depends combinationally on `out_ready`. Sits between the fetch queue and the register-read/hazard stage.

## Interface
- `XLEN`, 32, datapath width; legal values 32 or 64.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `flush`  input  1  drop all buffered entries and any input accepted this cycle.
- `in_valid`  input  1  instruction offered.
- `in_ready`  output  1  stage can accept; registered.
- `in_instr`  input  32  raw instruction word.
- `in_pc`  input  XLEN  instruction address.
- `out_valid`  output  1  decoded entry available.
- `out_ready`  input  1  consumer takes the entry.
- `out_instr`  output  32  instruction passed through.
- `out_pc`  output  XLEN  PC passed through.
- `out_imm`  output  XLEN  extended immediate.
- `out_fmt`  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- `out_target`  output  XLEN  `pc + imm` for B, J, AUIPC; 0 otherwise, including JALR.

## Operation
- Opcode map:
  - I: `0000011`, `1100111`, `0010011` with funct3 not 001/101, plus `0011011` when XLEN=64.
  - SHAMT: `0010011`/`0011011` with funct3 001/101.
  - S: `0100011`. B: `1100011`. U: `0110111`, `0010111`. J: `1101111`.
  - Anything else: NONE, imm 0.
- Immediate assembly, all sign-extended from `instr[31]` to XLEN:
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U: `{instr[31:12], 12'b0}`.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
- SHAMT: zero-extended `instr[24:20]`. Use `instr[25:20]` only when XLEN=64 and opcode is `0010011`. funct7 bits never appear in `out_imm`.
- Target: `in_pc + imm` modulo 2^XLEN. Computed only for B, J and AUIPC (`0010111`). LUI, I, S, SHAMT and NONE all give target 0.
- Buffer FSM:
  - States: EMPTY, ONE (main register full), TWO (main and skid full).
  - Accept = `in_valid & in_ready`. Take = `out_valid & out_ready`.
  - EMPTY, accept → ONE.
  - ONE, accept without take → TWO (new entry to skid).
  - ONE, accept with take → ONE (new entry into main).
  - ONE, take only → EMPTY.
  - TWO, take → ONE (skid moves to main).
  - `in_ready` = state != TWO, registered.
  - Output always comes from the main register. Order is strictly FIFO.
- `flush`: next state EMPTY regardless of accept or take. An entry accepted in the flush cycle is discarded. Flush overrides take; the consumer must ignore `out_*` in the flush cycle.

## Timing
- Latency: accept in cycle N → `out_valid` in cycle N+1 with the decoded data.
- Throughput: 1 instruction/cycle while `out_ready` is high.
- Backpressure: with `out_ready` low, at most 2 accepts occur. `in_ready` falls the cycle after the second accept and rises the cycle after the next take.
- Output stability: `out_*` hold stable while `out_valid & ~out_ready`.
- Reset (async assert, sync-safe deassert):
  - State EMPTY, `in_ready`=1, `out_valid`=0.
  - All data outputs 0, `out_fmt`=NONE.
  - Reset mid-stream discards all entries.
- Decode and adder logic sit before the register. No combinational path from any input to any output.

## Structure
- Package `imm_pkg`: format enum `imm_fmt_t` (3-bit), opcode constants `OP_LOAD`, `OP_IMM`, `OP_IMM32`, `OP_STORE`, `OP_BRANCH`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, and funct3 constants `F3_SLL`/`F3_SR`.
- Sub-module `imm_extract` (combinational, parametrised by XLEN): instr → imm, fmt, is_pcrel.
- `imm_decode_stage` instantiates it once on the input side. It owns the adder, the skid registers and the FSM.

## Test plan
- XLEN=32, `beq x0,x0,-4` = 0xFE000EE3, pc 0x100 → imm 0xFFFFFFFC, fmt B, target 0x000000FC, one cycle later.
- XLEN=32, `jal x1,2048` = 0x001000EF, pc 0x1000 → imm 0x00000800, fmt J, target 0x00001800.
- XLEN=32, `srai x1,x1,3` = 0x4030D093 → imm 0x00000003, fmt SHAMT, target 0. Unknown opcode 0x00000033 → imm 0, fmt NONE.
- XLEN=64, `lui x1,0x80000` = 0x800000B7 → imm 0xFFFFFFFF80000000, fmt U, target 0.
- Backpressure, instructions A, B, C, D:
  - Stream A, B, C, D with `in_valid` always high and `out_ready` low for 4 cycles → only A, B accepted; `in_ready` low until after the first take.
  - `out_ready` then high → outputs A, B, C, D in order, no loss or duplication.
- Flush and reset, same instructions:
  - In state TWO, assert `flush` while offering C → next cycle `out_valid`=0, `in_ready`=1, C never emerges.
  - Repeat with `rst_n` pulsed low mid-stream → same empty result, all outputs 0.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-decode stage.
// Latency: none (declarations only).
// Backpressure: not applicable.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: instr -> sign/zero-extended imm, format, pc-relative flag.
// Latency: purely combinational.
// Backpressure: none, no state.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            is_pcrel
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;
  logic [31:0] imm32;
  imm_fmt_t    f;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  // Every format fits in a signed 32-bit value; widen afterwards by sign extension.
  always_comb begin
    f        = FMT_NONE;
    imm32    = 32'd0;
    is_pcrel = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        f     = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_IMM, OP_IMM32: begin
        if (is_shift) begin
          f = FMT_SHAMT;
          // Bit 25 is part of the shift amount only for 64-bit non-word shifts.
          if (XLEN == 64 && opcode == OP_IMM) imm32 = {26'd0, instr[25:20]};
          else                                imm32 = {27'd0, instr[24:20]};
        end else if (opcode == OP_IMM || XLEN == 64) begin
          f     = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OP_STORE: begin
        f     = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        f        = FMT_B;
        is_pcrel = 1'b1;
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI: begin
        f     = FMT_U;
        imm32 = {instr[31:12], 12'd0};
      end
      OP_AUIPC: begin
        f        = FMT_U;
        is_pcrel = 1'b1;
        imm32    = {instr[31:12], 12'd0};
      end
      OP_JAL: begin
        f        = FMT_J;
        is_pcrel = 1'b1;
        imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        f     = FMT_NONE;
        imm32 = 32'd0;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));
  assign fmt = f;

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode with pc-relative target, buffered by a two-entry skid.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: holds up to two entries; in_ready is registered and drops only when both are full.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target
);

  logic [XLEN-1:0] d_imm;
  logic [2:0]      d_fmt;
  logic            d_pcrel;
  logic [XLEN-1:0] d_target;

  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_fmt;
  logic [XLEN-1:0] skid_target;

  buf_state_t state;
  logic       accept;
  logic       take;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr    (in_instr),
    .imm      (d_imm),
    .fmt      (d_fmt),
    .is_pcrel (d_pcrel)
  );

  // Target only for branch/jal/auipc; jalr is register-relative so it stays 0.
  always_comb begin
    d_target = '0;
    if (d_pcrel) d_target = in_pc + d_imm;
  end

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // Buffer FSM: main register drives the outputs, skid catches the entry that arrives while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_fmt     <= FMT_NONE;
      out_target  <= '0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      skid_imm    <= '0;
      skid_fmt    <= FMT_NONE;
      skid_target <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_instr  <= in_instr;
            out_pc     <= in_pc;
            out_imm    <= d_imm;
            out_fmt    <= d_fmt;
            out_target <= d_target;
            out_valid  <= 1'b1;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !take) begin
            skid_instr  <= in_instr;
            skid_pc     <= in_pc;
            skid_imm    <= d_imm;
            skid_fmt    <= d_fmt;
            skid_target <= d_target;
            in_ready    <= 1'b0;
            state       <= ST_TWO;
          end else if (accept && take) begin
            out_instr  <= in_instr;
            out_pc     <= in_pc;
            out_imm    <= d_imm;
            out_fmt    <= d_fmt;
            out_target <= d_target;
          end else if (take) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (take) begin
            out_instr  <= skid_instr;
            out_pc     <= skid_pc;
            out_imm    <= skid_imm;
            out_fmt    <= skid_fmt;
            out_target <= skid_target;
            in_ready   <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [63:0] in_pc = 64'd0;
  logic        out_ready = 1'b0;

  logic        r32, v32, r64, v64;
  logic [31:0] i32, i64;
  logic [31:0] pc32, imm32, tg32;
  logic [63:0] pc64, imm64, tg64;
  logic [2:0]  f32, f64;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_instr(i32), .out_pc(pc32), .out_imm(imm32), .out_fmt(f32), .out_target(tg32)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
    .out_instr(i64), .out_pc(pc64), .out_imm(imm64), .out_fmt(f64), .out_target(tg64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } item_t;

  int checks = 0;
  int failures = 0;
  item_t q[$];
  logic [31:0] seen[$];
  bit m_in_ready = 1'b1;
  bit m_out_valid = 1'b0;
  bit last_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the format rules, using plain integer arithmetic.
  function automatic void ref_decode(input logic [31:0] ins, input logic [63:0] pc, input int xlen,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output logic [63:0] tgt);
    longint v;
    bit pcrel;
    logic [6:0] op;
    logic [2:0] f3;
    logic [63:0] mask;
    op = ins[6:0];
    f3 = ins[14:12];
    v = 0;
    fmt = 3'd0;
    pcrel = 0;
    if ((op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5)) begin
      fmt = 3'd6;
      if (xlen == 64 && op == 7'h13) v = ins[25:20];
      else v = ins[24:20];
    end else if (op == 7'h03 || op == 7'h67 || op == 7'h13 || (op == 7'h1B && xlen == 64)) begin
      fmt = 3'd1;
      v = ins[31:20];
      if (ins[31]) v = v - 4096;
    end else if (op == 7'h23) begin
      fmt = 3'd2;
      v = ins[31:25] * 32 + ins[11:7];
      if (ins[31]) v = v - 4096;
    end else if (op == 7'h63) begin
      fmt = 3'd3;
      pcrel = 1;
      v = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
      if (ins[31]) v = v - 8192;
    end else if (op == 7'h37 || op == 7'h17) begin
      fmt = 3'd4;
      pcrel = (op == 7'h17);
      v = longint'(ins[31:12]) * 4096;
      if (ins[31]) v = v - 64'h1_0000_0000;
    end else if (op == 7'h6F) begin
      fmt = 3'd5;
      pcrel = 1;
      v = ins[31] * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
      if (ins[31]) v = v - 2097152;
    end
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    imm = 64'(v) & mask;
    tgt = pcrel ? ((pc + 64'(v)) & mask) : 64'd0;
  endfunction

  task automatic compare_all();
    logic [63:0] e_imm, e_tgt;
    logic [2:0]  e_fmt;
    chk("in_ready32", {63'd0, r32}, {63'd0, m_in_ready});
    chk("in_ready64", {63'd0, r64}, {63'd0, m_in_ready});
    chk("out_valid32", {63'd0, v32}, {63'd0, m_out_valid});
    chk("out_valid64", {63'd0, v64}, {63'd0, m_out_valid});
    if (m_out_valid) begin
      ref_decode(q[0].instr, q[0].pc, 32, e_imm, e_fmt, e_tgt);
      chk("instr32", {32'd0, i32}, {32'd0, q[0].instr});
      chk("pc32", {32'd0, pc32}, {32'd0, q[0].pc[31:0]});
      chk("imm32", {32'd0, imm32}, e_imm);
      chk("fmt32", {61'd0, f32}, {61'd0, e_fmt});
      chk("target32", {32'd0, tg32}, e_tgt);
      ref_decode(q[0].instr, q[0].pc, 64, e_imm, e_fmt, e_tgt);
      chk("instr64", {32'd0, i64}, {32'd0, q[0].instr});
      chk("pc64", pc64, q[0].pc);
      chk("imm64", imm64, e_imm);
      chk("fmt64", {61'd0, f64}, {61'd0, e_fmt});
      chk("target64", tg64, e_tgt);
    end
  endtask

  // One clock: record what the consumer takes, advance the queue model, then check at the falling edge.
  task automatic cycle();
    bit acc, tk;
    item_t it;
    if (rst_n && !flush && v32 && out_ready) seen.push_back(i32);
    @(posedge clk);
    acc = in_valid && m_in_ready;
    tk  = m_out_valid && out_ready;
    last_acc = acc && rst_n;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (tk) void'(q.pop_front());
      if (acc) begin
        it.instr = in_instr;
        it.pc = in_pc;
        q.push_back(it);
      end
    end
    m_out_valid = (q.size() > 0);
    m_in_ready = (q.size() < 2);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rdy"}, {62'd0, r32, r64}, 64'd3);
    chk({tag, "_vld"}, {62'd0, v32, v64}, 64'd0);
    chk({tag, "_d32"}, {32'd0, i32 | pc32 | imm32 | tg32}, 64'd0);
    chk({tag, "_d64"}, {32'd0, i64} | pc64 | imm64 | tg64, 64'd0);
    chk({tag, "_fmt"}, {58'd0, f32, f64}, 64'd0);
  endtask

  task automatic send_one(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc = pc;
    cycle();
    in_valid = 1'b0;
    chk("send_accepted", {63'd0, last_acc}, 64'd1);
  endtask

  logic [63:0] p_imm, p_tgt;
  logic [2:0]  p_fmt;
  logic [31:0] abcd [4];
  logic [6:0]  ops [12];
  int idx;

  initial begin
    abcd[0] = 32'hFE000EE3; abcd[1] = 32'h001000EF; abcd[2] = 32'h4030D093; abcd[3] = 32'h800000B7;
    ops[0] = 7'h03; ops[1] = 7'h67; ops[2] = 7'h13; ops[3] = 7'h1B; ops[4] = 7'h23; ops[5] = 7'h63;
    ops[6] = 7'h37; ops[7] = 7'h17; ops[8] = 7'h6F; ops[9] = 7'h33; ops[10] = 7'h00; ops[11] = 7'h7F;

    // Reset state.
    @(negedge clk);
    cycle();
    cycle();
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Pin the reference model with hand-computed values.
    ref_decode(32'hFE000EE3, 64'h100, 32, p_imm, p_fmt, p_tgt);
    chk("pin_beq", {p_imm[31:0], 29'd0, p_fmt}, {32'hFFFFFFFC, 32'd3});
    chk("pin_beq_tgt", p_tgt, 64'hFC);
    ref_decode(32'h001000EF, 64'h1000, 32, p_imm, p_fmt, p_tgt);
    chk("pin_jal", {p_imm[31:0], 29'd0, p_fmt}, {32'h800, 32'd5});
    chk("pin_jal_tgt", p_tgt, 64'h1800);
    ref_decode(32'h800000B7, 64'h40, 64, p_imm, p_fmt, p_tgt);
    chk("pin_lui64", p_imm, 64'hFFFFFFFF80000000);

    // Directed decodes, output one cycle after accept.
    out_ready = 1'b1;
    send_one(32'hFE000EE3, 64'h100);
    chk("beq_vld", {63'd0, v32}, 64'd1);
    chk("beq_imm", {32'd0, imm32}, 64'hFFFFFFFC);
    chk("beq_fmt", {61'd0, f32}, 64'd3);
    chk("beq_tgt", {32'd0, tg32}, 64'hFC);
    send_one(32'h001000EF, 64'h1000);
    chk("jal_imm", {32'd0, imm32}, 64'h800);
    chk("jal_tgt", {32'd0, tg32}, 64'h1800);
    send_one(32'h4030D093, 64'h2000);
    chk("srai_imm", {32'd0, imm32}, 64'h3);
    chk("srai_fmt_tgt", {29'd0, f32, tg32}, {29'd6, 32'd0});
    send_one(32'h00000033, 64'h2004);
    chk("none_imm_fmt", {29'd0, f32, imm32}, 64'd0);
    send_one(32'h800000B7, 64'h3000);
    chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    chk("lui64_fmt_tgt", {61'd0, f64} | tg64, 64'd4);
    cycle();

    // Backpressure: four cycles with out_ready low, only two accepts.
    out_ready = 1'b0;
    seen.delete();
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_instr = abcd[idx];
      in_pc = 64'h5000 + 64'(idx * 4);
      cycle();
      if (last_acc) idx++;
    end
    chk("bp_accepts", 64'(idx), 64'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 4 || q.size() > 0 || v32); c++) begin
      in_valid = (idx < 4);
      in_instr = abcd[idx % 4];
      in_pc = 64'h5000 + 64'(idx * 4);
      cycle();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(seen.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < seen.size()) chk("bp_order", {32'd0, seen[k]}, {32'd0, abcd[k]});

    // Flush in state TWO while offering C.
    out_ready = 1'b0;
    seen.delete();
    send_one(abcd[0], 64'h6000);
    send_one(abcd[1], 64'h6004);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = abcd[2];
    in_pc = 64'h6008;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_vld", {62'd0, v32, v64}, 64'd0);
    chk("flush_rdy", {62'd0, r32, r64}, 64'd3);
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("flush_nothing_out", 64'(seen.size()), 64'd0);

    // Reset pulsed mid-stream.
    out_ready = 1'b0;
    send_one(abcd[0], 64'h7000);
    send_one(abcd[1], 64'h7004);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    cycle();
    rst_n = 1'b1;
    check_zero_outputs("postrst");

    // Randomized traffic with occasional flush.
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = {$urandom()} & 32'hFFFFFF80;
      in_instr[6:0] = ops[$urandom_range(0, 11)];
      in_pc = {$urandom(), $urandom()};
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      cycle();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
